uart_mem_ctrl: RTL and testbench

//   Shares the uart_comm byte channel between two CPU memory requesters:

---
 rtl/uart_mem_ctrl.sv | 156 +++++++++++++++
 tb/tb_uart_mem_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mem_ctrl.sv
// rtl/uart_mem_ctrl.sv - arbitrates two CPU memory ports onto the uart_comm byte FIFOs
module uart_mem_ctrl #(
    parameter bit WRITE_ACK   = 1'b1,
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req0,
    input  logic        req1,
    input  logic        rw0,
    input  logic        rw1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    input  logic [3:0]  wmask0,
    input  logic [3:0]  wmask1,
    output logic        ack0,
    output logic        ack1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic        send_flag,
    output logic [7:0]  send_data,
    input  logic        sendable,
    output logic        recv_flag,
    input  logic [7:0]  recv_data,
    input  logic        receivable,
    output logic        busy
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_HDR  = 3'd1;
    localparam logic [2:0] S_ADDR = 3'd2;
    localparam logic [2:0] S_DATA = 3'd3;
    localparam logic [2:0] S_RESP = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    logic [2:0]  state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        last_q;
    logic        port_q;
    logic        rw_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wmask_q;
    logic [23:0] rbuf_q;
    logic        ack0_q, ack1_q;
    logic [31:0] rdata0_q, rdata1_q;

    logic gnt_port;
    logic send_active;
    logic resp_last;
    logic enter_done;

    function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] i);
        logic [31:0] s;
        s = w >> {i, 3'b000};
        return s[7:0];
    endfunction

    // Contention under round-robin goes to the port not served last; otherwise port 0 wins.
    assign gnt_port    = (ROUND_ROBIN && req0 && req1) ? ~last_q : ~req0;
    assign send_active = (state_q == S_HDR) || (state_q == S_ADDR) || (state_q == S_DATA);
    assign send_flag   = send_active && sendable;
    assign recv_flag   = (state_q == S_RESP) && receivable;
    assign resp_last   = rw_q ? 1'b1 : (cnt_q == 2'd3);
    assign enter_done  = (state_d == S_DONE) && (state_q != S_DONE);

    always_comb begin
        send_data = 8'h00;
        case (state_q)
            S_HDR:   send_data = {rw_q, port_q, 2'b00, wmask_q};
            S_ADDR:  send_data = byte_sel(addr_q, cnt_q);
            S_DATA:  send_data = byte_sel(wdata_q, cnt_q);
            default: send_data = 8'h00;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: if (req0 || req1) state_d = S_HDR;
            S_HDR: if (send_flag) begin
                state_d = S_ADDR;
                cnt_d   = 2'd0;
            end
            // The 2-bit counter wraps to 0 on the fourth byte, ready for the next phase.
            S_ADDR: if (send_flag) begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) state_d = rw_q ? S_DATA : S_RESP;
            end
            S_DATA: if (send_flag) begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) state_d = WRITE_ACK ? S_RESP : S_DONE;
            end
            S_RESP: if (recv_flag) begin
                cnt_d = resp_last ? 2'd0 : cnt_q + 2'd1;
                if (resp_last) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_IDLE;
            cnt_q    <= 2'd0;
            last_q   <= 1'b1;
            port_q   <= 1'b0;
            rw_q     <= 1'b0;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            wmask_q  <= 4'h0;
            rbuf_q   <= 24'h0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            rdata0_q <= 32'h0;
            rdata1_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack0_q  <= enter_done && !port_q;
            ack1_q  <= enter_done && port_q;
            if (state_q == S_IDLE && (req0 || req1)) begin
                port_q  <= gnt_port;
                last_q  <= gnt_port;
                rw_q    <= gnt_port ? rw1 : rw0;
                addr_q  <= gnt_port ? addr1 : addr0;
                wdata_q <= gnt_port ? wdata1 : wdata0;
                wmask_q <= (gnt_port ? rw1 : rw0) ? (gnt_port ? wmask1 : wmask0) : 4'h0;
            end
            // Read response arrives little-endian; the last byte goes straight into rdata.
            if (recv_flag && !rw_q) begin
                if (resp_last) begin
                    if (port_q) rdata1_q <= {recv_data, rbuf_q};
                    else        rdata0_q <= {recv_data, rbuf_q};
                end else begin
                    case (cnt_q)
                        2'd0:    rbuf_q[7:0]   <= recv_data;
                        2'd1:    rbuf_q[15:8]  <= recv_data;
                        default: rbuf_q[23:16] <= recv_data;
                    endcase
                end
            end
        end
    end

    assign ack0   = ack0_q;
    assign ack1   = ack1_q;
    assign rdata0 = rdata0_q;
    assign rdata1 = rdata1_q;
    assign busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_mem_ctrl.sv
// tb/tb_uart_mem_ctrl.sv - directed self-checking bench for uart_mem_ctrl
module tb_uart_mem_ctrl;

    typedef struct {
        logic        rw;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } txn_t;

    typedef struct {
        logic        port;
        logic        rw;
        logic [31:0] rdata;
    } ack_t;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        RST;
    logic        req0, req1, rw0, rw1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic [3:0]  wmask0, wmask1;
    logic        ack0, ack1;
    logic [31:0] rdata0, rdata1;
    logic        send_flag, sendable, recv_flag, receivable, busy;
    logic [7:0]  send_data, recv_data;

    logic        fp_rst;
    logic        fp_ack0, fp_ack1, fp_send_flag, fp_recv_flag, fp_busy;
    logic [31:0] fp_rdata0, fp_rdata1;
    logic [7:0]  fp_send_data;

    uart_mem_ctrl #(.WRITE_ACK(1'b1), .ROUND_ROBIN(1'b1)) dut (
        .CLK(CLK), .RST(RST),
        .req0(req0), .req1(req1), .rw0(rw0), .rw1(rw1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .wmask0(wmask0), .wmask1(wmask1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .send_flag(send_flag), .send_data(send_data), .sendable(sendable),
        .recv_flag(recv_flag), .recv_data(recv_data), .receivable(receivable),
        .busy(busy)
    );

    uart_mem_ctrl #(.WRITE_ACK(1'b1), .ROUND_ROBIN(1'b0)) dut_fp (
        .CLK(CLK), .RST(fp_rst),
        .req0(1'b1), .req1(1'b1), .rw0(1'b0), .rw1(1'b0),
        .addr0(32'h0), .addr1(32'h4), .wdata0(32'h0), .wdata1(32'h0),
        .wmask0(4'h0), .wmask1(4'h0),
        .ack0(fp_ack0), .ack1(fp_ack1), .rdata0(fp_rdata0), .rdata1(fp_rdata1),
        .send_flag(fp_send_flag), .send_data(fp_send_data), .sendable(1'b1),
        .recv_flag(fp_recv_flag), .recv_data(8'h5A), .receivable(1'b1),
        .busy(fp_busy)
    );

    txn_t       txq0[$], txq1[$];
    logic [7:0] exp_bytes[$];
    ack_t       exp_acks[$];
    logic [7:0] rx_q[$];
    logic [7:0] sent_log[$];

    int checks = 0, passes = 0;
    int cyc = 0, sent_cnt = 0, abort_cnt = 0, abort_seen = 0;
    int rise0 = 0, rise1 = 0, lat0 = -1, lat1 = -1;
    logic rst_prev = 1'b1, pop_pend = 1'b0, ack_seen0 = 1'b0, ack_seen1 = 1'b0;
    logic req0_prev = 1'b0, req1_prev = 1'b0;
    logic rx_en = 1'b1, rx_tog = 1'b0;
    logic [31:0] m_rdata0 = 32'h0, m_rdata1 = 32'h0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Model: packet layout, arbitration and response decoding from the protocol rules.
    function automatic int pkt_len(input txn_t t);
        return t.rw ? 9 : 5;
    endfunction

    function automatic logic [7:0] pkt_byte(input logic port, input txn_t t, input int i);
        logic [31:0] w;
        if (i == 0) return {t.rw, port, 2'b00, (t.rw ? t.wmask : 4'h0)};
        w = (i <= 4) ? (t.addr >> (8 * (i - 1))) : (t.wdata >> (8 * (i - 5)));
        return w[7:0];
    endfunction

    function automatic logic rr_pick(input logic r0, input logic r1, input logic last);
        if (r0 && r1) return ~last;
        return r1 && !r0;
    endfunction

    task automatic expect_txn(input logic port, input txn_t t, input logic [31:0] resp);
        ack_t a;
        for (int i = 0; i < pkt_len(t); i++) exp_bytes.push_back(pkt_byte(port, t, i));
        if (t.rw) rx_q.push_back(8'h00);
        else for (int i = 0; i < 4; i++) rx_q.push_back(8'((resp >> (8 * i)) & 32'hFF));
        a.port = port; a.rw = t.rw; a.rdata = resp;
        exp_acks.push_back(a);
        if (port) txq1.push_back(t); else txq0.push_back(t);
    endtask

    always @(posedge CLK) begin
        cyc++;
        rst_prev = RST;
        if (RST) begin
            m_rdata0 = 32'h0;
            m_rdata1 = 32'h0;
        end
    end

    // Compare process: every cycle, against the model's byte stream, ack order and rdata.
    always @(negedge CLK) begin
        ack_t e;
        chk("send_recv_excl", 32'(send_flag && recv_flag), 32'd0);
        chk("ack_excl", 32'(ack0 && ack1), 32'd0);
        chk("send_when_full", 32'(send_flag && !sendable), 32'd0);
        chk("pop_when_empty", 32'(recv_flag && !receivable), 32'd0);
        if (rst_prev) begin
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_acks", {30'd0, ack1, ack0}, 32'd0);
            chk("rst_rdata0", rdata0, 32'h0);
            chk("rst_rdata1", rdata1, 32'h0);
        end
        if (send_flag) begin
            sent_log.push_back(send_data);
            sent_cnt++;
            if (exp_bytes.size() == 0) chk("unexpected_send", {24'd0, send_data}, 32'hFFFF_FFFF);
            else chk("send_byte", {24'd0, send_data}, {24'd0, exp_bytes.pop_front()});
        end
        pop_pend = recv_flag;
        if (req0 && !req0_prev) rise0 = cyc;
        if (req1 && !req1_prev) rise1 = cyc;
        req0_prev = req0;
        req1_prev = req1;
        if (ack0 || ack1) begin
            if (ack0) lat0 = cyc - rise0;
            if (ack1) lat1 = cyc - rise1;
            if (exp_acks.size() == 0) chk("unexpected_ack", {30'd0, ack1, ack0}, 32'd0);
            else begin
                e = exp_acks.pop_front();
                chk("ack_port", 32'(ack1), 32'(e.port));
                if (!e.rw) begin
                    if (e.port) m_rdata1 = e.rdata;
                    else m_rdata0 = e.rdata;
                end
            end
        end
        chk("rdata0", rdata0, m_rdata0);
        chk("rdata1", rdata1, m_rdata1);
        ack_seen0 = ack0;
        ack_seen1 = ack1;
    end

    // Host side of the uart_comm receive FIFO (first-word-fall-through).
    always @(posedge CLK) begin
        #2;
        if (pop_pend) begin
            if (rx_q.size() == 0) chk("pop_of_empty_fifo", 32'd1, 32'd0);
            else void'(rx_q.pop_front());
        end
        rx_en      = rx_tog ? ~rx_en : 1'b1;
        receivable = rx_en && (rx_q.size() != 0);
        recv_data  = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
    end

    // Requesters: hold req until ack, then present the next queued access or drop.
    always @(posedge CLK) begin
        txn_t t;
        #3;
        if (abort_cnt != abort_seen) begin
            abort_seen = abort_cnt;
            txq0.delete();
            txq1.delete();
            req0 = 1'b0;
            req1 = 1'b0;
        end else begin
            if (ack_seen0 || !req0) begin
                if (txq0.size() != 0) begin
                    t = txq0.pop_front();
                    req0 = 1'b1; rw0 = t.rw; addr0 = t.addr; wdata0 = t.wdata; wmask0 = t.wmask;
                end else req0 = 1'b0;
            end
            if (ack_seen1 || !req1) begin
                if (txq1.size() != 0) begin
                    t = txq1.pop_front();
                    req1 = 1'b1; rw1 = t.rw; addr1 = t.addr; wdata1 = t.wdata; wmask1 = t.wmask;
                end else req1 = 1'b0;
            end
        end
    end

    task automatic wait_done(input string nm);
        int n = 0;
        while ((exp_acks.size() != 0 || exp_bytes.size() != 0) && n < 2000) begin
            @(posedge CLK);
            n++;
        end
        if (n >= 2000) begin
            chk({nm, "_timeout"}, 32'd1, 32'd0);
            exp_acks.delete();
            exp_bytes.delete();
        end
        repeat (3) @(posedge CLK);
        #1;
        chk({nm, "_rx_left"}, 32'(rx_q.size()), 32'd0);
    endtask

    task automatic wait_sent(input int target);
        int n = 0;
        while (sent_cnt < target && n < 500) begin
            @(posedge CLK);
            #1;
            n++;
        end
        if (n >= 500) chk("wait_sent_timeout", 32'(sent_cnt), 32'(target));
    endtask

    task automatic chk_log(input string nm, input logic [7:0] lit[], input int len);
        chk({nm, "_len"}, 32'(sent_log.size()), 32'(len));
        for (int i = 0; i < len && i < sent_log.size(); i++)
            chk($sformatf("%s_b%0d", nm, i), {24'd0, sent_log[i]}, {24'd0, lit[i]});
    endtask

    initial begin
        logic        last;
        logic        p;
        logic [7:0]  lit[];
        int          n0, n1, base;
        txn_t        t;

        RST = 1'b1; fp_rst = 1'b1; sendable = 1'b1;
        req0 = 1'b0; req1 = 1'b0; rw0 = 1'b0; rw1 = 1'b0;
        addr0 = 32'h0; addr1 = 32'h0; wdata0 = 32'h0; wdata1 = 32'h0;
        wmask0 = 4'h0; wmask1 = 4'h0;
        receivable = 1'b0; recv_data = 8'h00;

        // Both ports requesting from reset: alternate starting with port 0.
        last = 1'b1;
        for (int k = 0; k < 6; k++) begin
            p = rr_pick(1'b1, 1'b1, last);
            last = p;
            t = '{rw: 1'b0, addr: 32'h100 * k + (p ? 32'h4 : 32'h0), wdata: 32'h0, wmask: 4'h0};
            expect_txn(p, t, 32'h1111_1111 * (k + 1));
        end
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        wait_done("rr_alt");
        chk("rr_rdata0_lit", rdata0, 32'h5555_5555);
        chk("rr_rdata1_lit", rdata1, 32'h6666_6666);

        sent_log.delete();
        expect_txn(1'b1, '{rw: 1'b0, addr: 32'h0000_1004, wdata: 32'h0, wmask: 4'hF}, 32'h1234_5678);
        wait_done("read1");
        lit = '{8'h40, 8'h04, 8'h10, 8'h00, 8'h00};
        chk_log("read1", lit, 5);
        chk("read1_rdata_lit", rdata1, 32'h1234_5678);
        chk("read1_latency", 32'(lat1), 32'd10);

        sent_log.delete();
        expect_txn(1'b0, '{rw: 1'b1, addr: 32'h20, wdata: 32'hDEAD_BEEF, wmask: 4'b0011}, 32'h0);
        wait_done("write0");
        lit = '{8'h83, 8'h20, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        chk_log("write0", lit, 9);
        chk("write0_rdata_kept", rdata0, 32'h5555_5555);
        chk("write0_latency", 32'(lat0), 32'd11);

        sent_log.delete();
        rx_tog = 1'b1;
        base = sent_cnt;
        expect_txn(1'b0, '{rw: 1'b0, addr: 32'h0000_ABCD, wdata: 32'h0, wmask: 4'h0}, 32'hCAFE_F00D);
        wait_sent(base + 3);
        sendable = 1'b0;
        repeat (10) @(posedge CLK);
        #1 sendable = 1'b1;
        wait_done("stall");
        rx_tog = 1'b0;
        lit = '{8'h00, 8'hCD, 8'hAB, 8'h00, 8'h00};
        chk_log("stall", lit, 5);
        chk("stall_rdata_lit", rdata0, 32'hCAFE_F00D);

        // Reset lands while the second write-data byte is on the wire.
        base = sent_cnt;
        expect_txn(1'b1, '{rw: 1'b1, addr: 32'h44, wdata: 32'h0102_0304, wmask: 4'hF}, 32'h0);
        wait_sent(base + 6);
        RST = 1'b1;
        abort_cnt++;
        @(posedge CLK);
        #1 RST = 1'b0;
        exp_bytes.delete();
        exp_acks.delete();
        rx_q.delete();
        repeat (4) @(posedge CLK);
        #1;
        chk("after_rst_busy", 32'(busy), 32'd0);
        chk("after_rst_rdata0", rdata0, 32'h0);
        expect_txn(1'b0, '{rw: 1'b0, addr: 32'h100, wdata: 32'h0, wmask: 4'h0}, 32'h89AB_CDEF);
        wait_done("post_rst_read");
        chk("post_rst_rdata_lit", rdata0, 32'h89AB_CDEF);

        // Fixed priority with both ports held: port 0 every 11 cycles, port 1 never.
        @(posedge CLK);
        #1 fp_rst = 1'b0;
        n0 = 0; n1 = 0;
        repeat (200) begin
            @(negedge CLK);
            if (fp_ack0) n0++;
            if (fp_ack1) n1++;
            chk("fp_excl", 32'(fp_send_flag && fp_recv_flag), 32'd0);
        end
        chk("fp_port0_acks", 32'(n0), 32'd18);
        chk("fp_port1_acks", 32'(n1), 32'd0);
        chk("fp_rdata0", fp_rdata0, 32'h5A5A_5A5A);
        chk("fp_rdata1", fp_rdata1, 32'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
